t8x8_ctrl: RTL

T8X8_CTRL -- requirements
Module: t8x8_ctrl

---
 rtl/t8x8_pkg.sv | 12 +
 rtl/t8x8_valid_pipe.sv | 49 ++++
 rtl/t8x8_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/t8x8_pkg.sv
// rtl/t8x8_pkg.sv - shared defaults and FSM state type for the 8x8 transpose controller
package t8x8_pkg;

  localparam int ROWS_DEF = 8;
  localparam int LAT_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/t8x8_valid_pipe.sv
// rtl/t8x8_valid_pipe.sv - enabled shift register tracking {valid, last} of rows inside the array
module valid_pipe #(
  parameter int LAT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o,
  output logic any_valid_o
);

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] valid_d;
  logic [LAT-1:0] last_q;
  logic [LAT-1:0] last_d;

  // Next stage contents: shift by one position only on enabled array cycles.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    if (en_i) begin
      valid_d[0] = valid_i;
      last_d[0]  = last_i;
      for (int i = 1; i < LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
      end
    end
  end

  // Stage registers, cleared so nothing is considered in flight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o     = valid_q[LAT-1];
  assign last_o      = last_q[LAT-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/t8x8_ctrl.sv
// rtl/t8x8_ctrl.sv - row sequencing, flow control and tile counting for an 8x8 transpose array
module t8x8_ctrl
  import t8x8_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_transpose,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             arr_enable,
  output logic             arr_start,
  output logic             arr_do_transpose,
  output logic             busy,
  output logic [CNT_W-1:0] tile_cnt
);

  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  state_e           state_q;
  logic [RCW-1:0]   row_cnt_q;
  logic             mode_q;
  logic [CNT_W-1:0] tile_cnt_q;

  logic pipe_valid;
  logic pipe_last;
  logic pipe_any;
  logic stall;
  logic hole;
  logic mode_block;
  logic accept;
  logic row_last;

  // Array may only advance when downstream is not blocking and upstream has
  // no gap in the middle of a tile; held low while in reset.
  assign hole       = (state_q == LOAD) & ~in_valid;
  assign out_valid  = pipe_valid & ~hole;
  assign out_last   = pipe_last & out_valid;
  assign stall      = out_valid & ~out_ready;
  assign arr_enable = reset_n & ~stall & ~hole;

  // A mode change between tiles has to wait until the array is empty.
  assign mode_block = (state_q == IDLE) & (cfg_transpose != mode_q) & pipe_any;
  assign in_ready   = arr_enable & ~mode_block;
  assign accept     = in_valid & in_ready;
  assign row_last   = accept & (row_cnt_q == LAST_ROW);

  assign arr_start        = (state_q == LOAD) | accept;
  assign arr_do_transpose = mode_q;
  assign busy             = (state_q == LOAD) | pipe_any;
  assign tile_cnt         = tile_cnt_q;

  // Tile loading FSM: counts accepted rows and captures the mode at tile start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else if (arr_enable && accept) begin
      if (state_q == IDLE) begin
        mode_q <= cfg_transpose;
      end
      if (row_cnt_q == LAST_ROW) begin
        state_q   <= IDLE;
        row_cnt_q <= '0;
      end else begin
        state_q   <= LOAD;
        row_cnt_q <= row_cnt_q + RCW'(1);
      end
    end
  end

  // Count tiles whose final row has been handed downstream; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_cnt_q <= '0;
    end else if (out_valid && out_ready && out_last) begin
      tile_cnt_q <= tile_cnt_q + CNT_W'(1);
    end
  end

  valid_pipe #(
    .LAT(LAT)
  ) u_valid_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (arr_enable),
    .valid_i    (accept),
    .last_i     (row_last),
    .valid_o    (pipe_valid),
    .last_o     (pipe_last),
    .any_valid_o(pipe_any)
  );

endmodule
